// File: rtl/writeback_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : common
// Description : Shared types for the writeback stage: scalar aliases, the CSR
//               address width and the commit record pushed for every
//               retirement.
// Revision    : 1.0 - initial release
// ============================================================================
package common;

    localparam int CSR_ADDR_W = 12;

    typedef logic [4:0]  u5;
    typedef logic [11:0] u12;
    typedef logic [63:0] u64;

    // One retired instruction as seen by the commit/difftest interface.
    typedef struct packed {
        logic        isWb;
        u5           wd;
        u64          wdata;
        u64          instrAddr;
        logic [31:0] instr;
    } WB_COMMIT_ENTRY;

endpackage
`default_nettype wire

// File: rtl/writeback_pipe_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_commit_fifo
// Description : Commit record FIFO. Power-of-two depth with wrapping pointers
//               and an occupancy counter one bit wider than the pointers. The
//               head reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_fifo
    import common::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = WB_COMMIT_ENTRY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  ENTRY_T                   i_data,
    input  logic                     i_pop,
    output ENTRY_T                   o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ENTRY_T             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage array; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head presentation, forced to zero while empty so reset leaves clean outputs.
    always_comb begin
        o_head = '0;
        if (!o_empty) begin
            o_head = r_mem[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module      : writeback_pipe
// Description : Writeback stage with per-cycle valid/ready handshake. Issues
//               one-cycle GPR, CSR and privilege write pulses for every
//               accepted retirement and queues a commit record for the
//               commit/difftest interface.
//               Optional macro WRITEBACK_BYPASS_EN enables the same-cycle
//               forwarding port (fwd_*); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_pipe
    import common::*;
#(
    parameter int XLEN         = 64,
    parameter int CSR_PORTS    = 3,
    parameter int COMMIT_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_isWriteBack,
    input  logic                            in_isMemRead,
    input  logic                            in_isJump,
    input  logic [4:0]                      in_wd,
    input  logic [XLEN-1:0]                 in_aluOut,
    input  logic [XLEN-1:0]                 in_memOut,
    input  logic [XLEN-1:0]                 in_pcPlus4,
    input  logic [XLEN-1:0]                 in_instrAddr,
    input  logic [31:0]                     in_instr,
    input  logic [CSR_PORTS-1:0]            in_csr_we,
    input  logic [CSR_ADDR_W*CSR_PORTS-1:0] in_csr_addr,
    input  logic [XLEN*CSR_PORTS-1:0]       in_csr_data,
    input  logic                            in_priv_we,
    input  logic [1:0]                      in_priv,
    output logic                            wbEn,
    output logic [4:0]                      wd,
    output logic [XLEN-1:0]                 wbData,
    output logic [CSR_PORTS-1:0]            csr_we,
    output logic [CSR_ADDR_W*CSR_PORTS-1:0] csr_addr,
    output logic [XLEN*CSR_PORTS-1:0]       csr_data,
    output logic                            priv_we,
    output logic [1:0]                      priv,
    output logic                            commit_valid,
    input  logic                            commit_ready,
    output logic                            commit_isWb,
    output logic [4:0]                      commit_wd,
    output logic [XLEN-1:0]                 commit_wdata,
    output logic [XLEN-1:0]                 commit_instrAddr,
    output logic [31:0]                     commit_instr,
    output logic                            fwd_valid,
    output logic [4:0]                      fwd_wd,
    output logic [XLEN-1:0]                 fwd_data
);

    localparam int CNT_W = $clog2(COMMIT_DEPTH) + 1;

    logic                            w_accept;
    logic                            w_gpr_write;
    logic [XLEN-1:0]                 w_result;
    WB_COMMIT_ENTRY                  w_push_entry;
    WB_COMMIT_ENTRY                  w_head;
    logic [CNT_W-1:0]                w_count;
    logic                            w_full;
    logic                            w_empty;

    logic                            r_wb_en;
    logic [4:0]                      r_wd;
    logic [XLEN-1:0]                 r_wb_data;
    logic [CSR_PORTS-1:0]            r_csr_we;
    logic [CSR_ADDR_W*CSR_PORTS-1:0] r_csr_addr;
    logic [XLEN*CSR_PORTS-1:0]       r_csr_data;
    logic                            r_priv_we;
    logic [1:0]                      r_priv;

    // in_ready depends only on registered occupancy, never on commit_ready.
    assign in_ready    = ~w_full;
    assign w_accept    = in_valid & in_ready;
    assign w_gpr_write = (in_isWriteBack | in_isJump) & (in_wd != 5'd0);

    // Result source: load data wins over link address, which wins over ALU.
    always_comb begin
        w_result = in_aluOut;
        if (in_isMemRead) begin
            w_result = in_memOut;
        end else if (in_isJump) begin
            w_result = in_pcPlus4;
        end
    end

    // One-cycle write pulses; enables drop whenever no retirement is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_en    <= 1'b0;
            r_wd       <= '0;
            r_wb_data  <= '0;
            r_csr_we   <= '0;
            r_csr_addr <= '0;
            r_csr_data <= '0;
            r_priv_we  <= 1'b0;
            r_priv     <= '0;
        end else begin
            r_wb_en   <= w_accept & w_gpr_write;
            r_csr_we  <= w_accept ? in_csr_we : '0;
            r_priv_we <= w_accept & in_priv_we;
            if (w_accept) begin
                r_wd       <= in_wd;
                r_wb_data  <= w_result;
                r_csr_addr <= in_csr_addr;
                r_csr_data <= in_csr_data;
                r_priv     <= in_priv;
            end
        end
    end

    assign wbEn     = r_wb_en;
    assign wd       = r_wd;
    assign wbData   = r_wb_data;
    assign csr_we   = r_csr_we;
    assign csr_addr = r_csr_addr;
    assign csr_data = r_csr_data;
    assign priv_we  = r_priv_we;
    assign priv     = r_priv;

    // Commit record assembled from the same selected result as the GPR pulse.
    always_comb begin
        w_push_entry           = '0;
        w_push_entry.isWb      = w_gpr_write;
        w_push_entry.wd        = in_wd;
        w_push_entry.wdata     = u64'(w_result);
        w_push_entry.instrAddr = u64'(in_instrAddr);
        w_push_entry.instr     = in_instr;
    end

    wb_commit_fifo #(
        .DEPTH   (COMMIT_DEPTH),
        .ENTRY_T (WB_COMMIT_ENTRY)
    ) u_commit_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (w_push_entry),
        .i_pop   (commit_ready & ~w_empty),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign commit_valid     = (w_count != '0);
    assign commit_isWb      = w_head.isWb;
    assign commit_wd        = w_head.wd;
    assign commit_wdata     = w_head.wdata[XLEN-1:0];
    assign commit_instrAddr = w_head.instrAddr[XLEN-1:0];
    assign commit_instr     = w_head.instr;

`ifdef WRITEBACK_BYPASS_EN
    // Same-cycle forward of the accepted GPR result, one cycle ahead of wbEn.
    assign fwd_valid = w_accept & w_gpr_write;
    assign fwd_wd    = in_wd;
    assign fwd_data  = w_result;
`else
    assign fwd_valid = 1'b0;
    assign fwd_wd    = '0;
    assign fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_pipe
// Description : Directed bench for writeback_pipe: a vector table for the
//               single-cycle behaviour plus hand sequences for FIFO full,
//               steady push/pop, and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic         in_isWriteBack, in_isMemRead, in_isJump;
    logic [4:0]   in_wd;
    logic [63:0]  in_aluOut, in_memOut, in_pcPlus4, in_instrAddr;
    logic [31:0]  in_instr;
    logic [2:0]   in_csr_we;
    logic [35:0]  in_csr_addr;
    logic [191:0] in_csr_data;
    logic         in_priv_we;
    logic [1:0]   in_priv;
    logic         wbEn;
    logic [4:0]   wd;
    logic [63:0]  wbData;
    logic [2:0]   csr_we;
    logic [35:0]  csr_addr;
    logic [191:0] csr_data;
    logic         priv_we;
    logic [1:0]   priv;
    logic         commit_valid, commit_ready, commit_isWb;
    logic [4:0]   commit_wd;
    logic [63:0]  commit_wdata, commit_instrAddr;
    logic [31:0]  commit_instr;
    logic         fwd_valid;
    logic [4:0]   fwd_wd;
    logic [63:0]  fwd_data;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    writeback_pipe #(.XLEN(64), .CSR_PORTS(3), .COMMIT_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_isWriteBack(in_isWriteBack), .in_isMemRead(in_isMemRead), .in_isJump(in_isJump),
        .in_wd(in_wd), .in_aluOut(in_aluOut), .in_memOut(in_memOut), .in_pcPlus4(in_pcPlus4),
        .in_instrAddr(in_instrAddr), .in_instr(in_instr),
        .in_csr_we(in_csr_we), .in_csr_addr(in_csr_addr), .in_csr_data(in_csr_data),
        .in_priv_we(in_priv_we), .in_priv(in_priv),
        .wbEn(wbEn), .wd(wd), .wbData(wbData),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_data(csr_data),
        .priv_we(priv_we), .priv(priv),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_isWb(commit_isWb), .commit_wd(commit_wd), .commit_wdata(commit_wdata),
        .commit_instrAddr(commit_instrAddr), .commit_instr(commit_instr),
        .fwd_valid(fwd_valid), .fwd_wd(fwd_wd), .fwd_data(fwd_data)
    );

    typedef struct {
        logic        v, is_wb, is_mem, is_jmp;
        logic [4:0]  wd;
        logic [63:0] alu, mem, pc4;
        logic [2:0]  csr;
        logic        pwe;
        logic [1:0]  pr;
        logic [2:0]  e_csr;
        logic        e_pwe;
        logic        e_wb;
        logic [63:0] e_res;
        logic        e_cv;
        logic        e_cwb;
    } vec_t;

    function automatic vec_t mk(logic v, logic is_wb, logic is_mem, logic is_jmp,
                                logic [4:0] wdv, logic [63:0] alu, logic [63:0] mem,
                                logic [63:0] pc4, logic [2:0] csr, logic pwe, logic [1:0] pr,
                                logic [2:0] e_csr, logic e_pwe, logic e_wb,
                                logic [63:0] e_res, logic e_cv, logic e_cwb);
        vec_t r;
        r.v = v; r.is_wb = is_wb; r.is_mem = is_mem; r.is_jmp = is_jmp;
        r.wd = wdv; r.alu = alu; r.mem = mem; r.pc4 = pc4;
        r.csr = csr; r.pwe = pwe; r.pr = pr;
        r.e_csr = e_csr; r.e_pwe = e_pwe; r.e_wb = e_wb;
        r.e_res = e_res; r.e_cv = e_cv; r.e_cwb = e_cwb;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic is_wb, input logic is_mem, input logic is_jmp,
                         input logic [4:0] wdv, input logic [63:0] alu, input logic [63:0] mem,
                         input logic [63:0] pc4, input logic [2:0] csr, input logic pwe,
                         input logic [1:0] pr, input logic [63:0] pc);
        in_valid = v; in_isWriteBack = is_wb; in_isMemRead = is_mem; in_isJump = is_jmp;
        in_wd = wdv; in_aluOut = alu; in_memOut = mem; in_pcPlus4 = pc4;
        in_csr_we = csr; in_priv_we = pwe; in_priv = pr;
        in_instrAddr = pc; in_instr = pc[31:0] ^ 32'h0000_0013;
    endtask

    vec_t vecs [11];

    initial begin
        rst = 1'b1;
        commit_ready = 1'b1;
        in_csr_addr = {12'h341, 12'h305, 12'h300};
        in_csr_data = {64'hC2, 64'hC1, 64'hC0};
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        #2;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_wbEn", wbEn, 0);
        chk("reset_csr_we", csr_we, 0);
        chk("reset_commit_valid", commit_valid, 0);
        chk("reset_commit_wdata", commit_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        //            v  wb mem jmp wd  alu                    mem      pc4     csr    pwe pr  e_csr  e_pwe e_wb e_res                  e_cv e_cwb
        vecs[0]  = mk(1, 1, 0, 0,  5, 64'h1234,              64'h9999, 64'h8,   3'b000, 0, 0, 3'b000, 0,   1,   64'h1234,              1,   1);
        vecs[1]  = mk(0, 1, 0, 0,  5, 64'h1234,              64'h0,    64'h0,   3'b111, 1, 3, 3'b000, 0,   0,   64'h1234,              0,   0);
        vecs[2]  = mk(1, 1, 1, 1,  7, 64'h1,                 64'hAAAA, 64'h8,   3'b000, 0, 0, 3'b000, 0,   1,   64'hAAAA,              1,   1);
        vecs[3]  = mk(1, 0, 0, 1,  0, 64'h1,                 64'h2,    64'h104, 3'b000, 0, 0, 3'b000, 0,   0,   64'h104,               1,   0);
        vecs[4]  = mk(1, 0, 0, 1,  1, 64'h1,                 64'h2,    64'h200, 3'b000, 0, 0, 3'b000, 0,   1,   64'h200,               1,   1);
        vecs[5]  = mk(1, 0, 0, 0,  3, 64'h55,                64'h66,   64'h77,  3'b000, 0, 0, 3'b000, 0,   0,   64'h55,                1,   0);
        vecs[6]  = mk(1, 0, 0, 0,  0, 64'h11,                64'h0,    64'h0,   3'b101, 1, 3, 3'b101, 1,   0,   64'h11,                1,   0);
        vecs[7]  = mk(0, 0, 0, 0,  0, 64'h0,                 64'h0,    64'h0,   3'b101, 1, 3, 3'b000, 0,   0,   64'h0,                 0,   0);
        vecs[8]  = mk(1, 1, 0, 0, 31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,  64'h0,   3'b000, 0, 0, 3'b000, 0,   1,   64'hFFFF_FFFF_FFFF_FFFF, 1,  1);
        vecs[9]  = mk(1, 1, 0, 0,  0, 64'h42,                64'h0,    64'h0,   3'b000, 0, 0, 3'b000, 0,   0,   64'h42,                1,   0);
        vecs[10] = mk(1, 1, 1, 0, 12, 64'h1,                 64'hBEEF, 64'h3,   3'b010, 1, 1, 3'b010, 1,   1,   64'hBEEF,              1,   1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].is_wb, vecs[i].is_mem, vecs[i].is_jmp, vecs[i].wd,
                  vecs[i].alu, vecs[i].mem, vecs[i].pc4, vecs[i].csr, vecs[i].pwe, vecs[i].pr,
                  64'h8000_0000 + 64'(i) * 4);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wbEn", i), wbEn, vecs[i].e_wb);
            if (vecs[i].e_wb) begin
                chk($sformatf("v%0d_wd", i), wd, vecs[i].wd);
                chk($sformatf("v%0d_wbData", i), wbData, vecs[i].e_res);
            end
            chk($sformatf("v%0d_csr_we", i), csr_we, vecs[i].e_csr);
            if (vecs[i].e_csr != 3'b000) begin
                chk($sformatf("v%0d_csr_addr", i), csr_addr, {12'h341, 12'h305, 12'h300});
                chk($sformatf("v%0d_csr_data0", i), csr_data[63:0], 64'hC0);
                chk($sformatf("v%0d_csr_data2", i), csr_data[191:128], 64'hC2);
            end
            chk($sformatf("v%0d_priv_we", i), priv_we, vecs[i].e_pwe);
            if (vecs[i].e_pwe) chk($sformatf("v%0d_priv", i), priv, vecs[i].pr);
            chk($sformatf("v%0d_commit_valid", i), commit_valid, vecs[i].e_cv);
            if (vecs[i].e_cv) begin
                chk($sformatf("v%0d_commit_isWb", i), commit_isWb, vecs[i].e_cwb);
                chk($sformatf("v%0d_commit_wd", i), commit_wd, vecs[i].wd);
                chk($sformatf("v%0d_commit_wdata", i), commit_wdata, vecs[i].e_res);
                chk($sformatf("v%0d_commit_pc", i), commit_instrAddr, 64'h8000_0000 + 64'(i) * 4);
            end
        end

        // One accept produces exactly one pulse
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("tail_wbEn_drop", wbEn, 0);
        chk("tail_csr_drop", csr_we, 0);

        // FIFO full: four accepts with the sink stalled
        commit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 5'(10 + i), 64'h100 + 64'(i), 0, 0, 0, 0, 0, 64'h100 + 64'(i));
            @(posedge clk);
        end
        @(negedge clk);
        drive(1, 1, 0, 0, 14, 64'h104, 0, 0, 0, 0, 0, 64'h104);
        #1;
        chk("full_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("full_offer_held", wbEn, 0);
        chk("full_head_hold_wd", commit_wd, 10);
        chk("full_head_hold_data", commit_wdata, 64'h100);
        chk("full_in_ready2", in_ready, 0);
        @(negedge clk);
        commit_ready = 1'b1;
        #1;
        chk("full_no_comb_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("full_ready_after_pop", in_ready, 1);
        chk("full_no_accept_on_pop", wbEn, 0);
        chk("full_pop1_wd", commit_wd, 11);
        @(posedge clk); #1;
        chk("full_5th_wbEn", wbEn, 1);
        chk("full_5th_wd", wd, 14);
        chk("full_pop2_wd", commit_wd, 12);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("full_pop3_wd", commit_wd, 13);
        @(posedge clk); #1;
        chk("full_pop4_wd", commit_wd, 14);
        chk("full_pop4_data", commit_wdata, 64'h104);
        @(posedge clk); #1;
        chk("full_drained", commit_valid, 0);

        // Steady push/pop at occupancy 2 across pointer wrap
        commit_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 3, 64'h1000 + 64'(i), 0, 0, 0, 0, 0, 0);
            @(posedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            commit_ready = 1'b1;
            drive(1, 1, 0, 0, 3, 64'h1002 + 64'(k), 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("pp%0d_head", k), commit_wdata, 64'h1001 + 64'(k));
            chk($sformatf("pp%0d_in_ready", k), in_ready, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("pp_drain_last", commit_wdata, 64'h100B);
        @(posedge clk); #1;
        chk("pp_drain_empty", commit_valid, 0);

        // Reset with three queued entries and a pending pulse
        commit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 0, 0, 5'(20 + i), 64'h2000 + 64'(i), 0, 0, (i == 2) ? 3'b111 : 3'b000,
                  (i == 2) ? 1'b1 : 1'b0, 1, 0);
            @(posedge clk);
        end
        #1;
        chk("rst_pre_wbEn", wbEn, 1);
        chk("rst_pre_csr_we", csr_we, 3'b111);
        rst = 1'b1;
        #1;
        chk("rst_mid_wbEn", wbEn, 0);
        chk("rst_mid_csr_we", csr_we, 0);
        chk("rst_mid_priv_we", priv_we, 0);
        chk("rst_mid_commit_valid", commit_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        commit_ready = 1'b1;
        drive(1, 1, 0, 0, 9, 64'h77, 0, 0, 0, 0, 0, 64'h40);
        #1;
`ifdef WRITEBACK_BYPASS_EN
        chk("fwd_valid", fwd_valid, 1);
        chk("fwd_wd", fwd_wd, 9);
        chk("fwd_data", fwd_data, 64'h77);
`else
        chk("fwd_tied_valid", fwd_valid, 0);
        chk("fwd_tied_data", fwd_data, 0);
`endif
        chk("post_rst_no_early_wbEn", wbEn, 0);
        @(posedge clk); #1;
        chk("post_rst_wbEn", wbEn, 1);
        chk("post_rst_wbData", wbData, 64'h77);
        chk("post_rst_commit_data", commit_wdata, 64'h77);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
